cpri_tx_burst_gen: RTL
======================

// Module: cpri_tx_burst_gen
// PURPOSE
//   Parametrised CPRI TX write-burst generator. It packs a sop-marked input word stream into
//   fixed-length bursts for the CPRI TX buffer: per-word write enable, word address, data,
//   channel tag and last flag. It sits between the PRB-combine datapath and the CPRI framer
//   buffer. It adds an input valid qualifier (gapped streams), multi-channel tagging and
//   sop-collision detection.
// PARAMETERS
//   DW        64  data word width
//   BURST_LEN 96  words per burst; must be >= 2
//   AW        7   address width; 2**AW >= BURST_LEN
//   NUM_CH    4   channel count; CHW = max(1,$clog2(NUM_CH)) (localparam)
// PORTS
//   clk           in   1    core clock
//   rst_n         in   1    synchronous reset, active low
//   i_sop         in   1    start of burst; honoured only with i_vld=1
//   i_ch          in   CHW  channel of burst, sampled at accepted sop
//   i_vld         in   1    input word valid
//   i_dat         in   DW   input word
//   o_cpri_wen    out  1    write beat
//   o_cpri_wch    out  CHW  channel tag of beat
//   o_cpri_waddr  out  AW   word index in burst, 0..BURST_LEN-1
//   o_cpri_wdata  out  DW   write data
//   o_cpri_wlast  out  1    final beat of a complete burst
//   o_busy        out  1    burst in progress (FSM in BURST)
//   o_sop_err     out  1    1-cycle pulse: sop arrived while a burst was active
// BEHAVIOUR
//   - FSM IDLE/BURST. Accept = i_vld & (i_sop | state==BURST). Word count cnt (AW bits).
//   - IDLE: i_sop&i_vld -> BURST. The word on that cycle is word 0. cnt<=1, ch latched.
//     i_vld without sop is dropped. i_sop with i_vld=0 is ignored.
//   - BURST: each i_vld word takes index cnt, then cnt++. The word at cnt==BURST_LEN-1 is last
//     and the FSM returns to IDLE. i_vld=0 cycles stall with no output beat.
//   - sop during BURST (including on the would-be last word): i_sop has priority. The current
//     burst is truncated with no wlast, o_sop_err pulses, and the sop word becomes word 0 of
//     the new burst with the new i_ch.
//   - sop on the cycle after a last word: normal start, no error. Back-to-back beats are gapless.
//   - Pipeline: stage 1 registers accept/index/ch/data/last. Stage 2 drives the outputs.
//     Input-to-output latency is exactly 2 cycles. o_sop_err aligns with word 0 of the new burst.
//   - o_cpri_waddr/wdata/wch update only on beats and hold otherwise.
//     o_cpri_wen/wlast/o_sop_err are 0 on non-beats.
//   - o_busy is registered: 1 from the cycle after the accepted sop until the cycle after the
//     last word is accepted.
//   - Reset (rst_n=0 at an edge) clears FSM, cnt, pipeline and all outputs to 0. This applies
//     mid-burst: the partial burst is discarded, no wlast. After release, words need a new sop.
// CONFIGURATION
//   CPRI_TX_BURST_STAT_EN defined: adds outputs o_burst_cnt[15:0] and o_err_cnt[15:0].
//     o_burst_cnt increments with each o_cpri_wlast beat.
//     o_err_cnt increments with each o_sop_err pulse.
//     Both saturate at 16'hFFFF and reset to 0.
//   Not defined: these ports and counters are absent. All other behaviour is identical.
// TESTING
//   1. Reset, sop ch=2, 96 contiguous vld words dat=k (0..95) -> wen for 96 cycles from
//      sop+2, waddr=k, wdata=k, wch=2, wlast only at waddr 95, o_sop_err never.
//   2. Same burst with i_vld toggling 1/0 -> 96 beats on alternate cycles, waddr contiguous
//      0..95, wlast on 96th valid word.
//   3. sop ch=1, sop ch=3 at word 40 -> beats 0..39 ch1 without wlast, o_sop_err with new
//      waddr 0, then 96 beats ch3 ending in wlast.
//   4. Two bursts, second sop the cycle after word 95 -> 192 gapless beats, two wlast,
//      no error. Plus: vld words in IDLE without sop -> no beats.
//   5. rst_n=0 for one cycle at word 50 -> all outputs 0 next cycle, o_busy=0. Remaining vld
//      words produce no beats until a new sop.
//   6. CPRI_TX_BURST_STAT_EN: 3 complete bursts + 1 truncating sop -> o_burst_cnt=3,
//      o_err_cnt=1. Forced preload 16'hFFFF + one burst -> stays 16'hFFFF.

Source files
------------

// File: rtl/cpri_tx_burst_gen_if.sv
// Stream-in / CPRI-write-out bundle for cpri_tx_burst_gen.
// The statistics ports exist only when CPRI_TX_BURST_STAT_EN is defined.
interface cpri_tx_burst_gen_if #(
  parameter int DW     = 64,
  parameter int AW     = 7,
  parameter int NUM_CH = 4
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic           i_sop;
  logic [CHW-1:0] i_ch;
  logic           i_vld;
  logic [DW-1:0]  i_dat;
  logic           o_cpri_wen;
  logic [CHW-1:0] o_cpri_wch;
  logic [AW-1:0]  o_cpri_waddr;
  logic [DW-1:0]  o_cpri_wdata;
  logic           o_cpri_wlast;
  logic           o_busy;
  logic           o_sop_err;
`ifdef CPRI_TX_BURST_STAT_EN
  logic [15:0]    o_burst_cnt;
  logic [15:0]    o_err_cnt;
`endif

  // Generator side: consumes the word stream, produces write beats.
  modport master (
    input  i_sop, i_ch, i_vld, i_dat,
    output o_cpri_wen, o_cpri_wch, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast,
    output o_busy, o_sop_err
`ifdef CPRI_TX_BURST_STAT_EN
    , output o_burst_cnt, o_err_cnt
`endif
  );

  modport slave (
    output i_sop, i_ch, i_vld, i_dat,
    input  o_cpri_wen, o_cpri_wch, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast,
    input  o_busy, o_sop_err
`ifdef CPRI_TX_BURST_STAT_EN
    , input o_burst_cnt, o_err_cnt
`endif
  );
endinterface

// File: rtl/cpri_tx_burst_gen.sv
// CPRI TX write-burst generator: packs a sop-marked, gapped word stream into fixed-length
// channel-tagged bursts. Optional burst/error counters under CPRI_TX_BURST_STAT_EN.
module cpri_tx_burst_gen #(
  parameter int DW        = 64,
  parameter int BURST_LEN = 96,
  parameter int AW        = 7,
  parameter int NUM_CH    = 4
) (
  input logic               clk,
  input logic               rst_n,
  cpri_tx_burst_gen_if.master bus
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(BURST_LEN - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]     state_r, state_nxt_s;
  logic [AW-1:0]  cnt_r, cnt_nxt_s;
  logic [CHW-1:0] ch_r;

  logic           start_s, accept_s, last_s, err_s;
  logic [AW-1:0]  idx_s;
  logic [CHW-1:0] beat_ch_s;

  logic           s1_vld_r, s1_last_r, s1_err_r;
  logic [AW-1:0]  s1_idx_r;
  logic [CHW-1:0] s1_ch_r;
  logic [DW-1:0]  s1_dat_r;

  logic           wen_r, wlast_r, sop_err_r, busy_r;
  logic [AW-1:0]  waddr_r;
  logic [CHW-1:0] wch_r;
  logic [DW-1:0]  wdata_r;

  // Accept/index decode and next-state; a new sop always wins, even over the last word.
  always_comb begin
    start_s     = bus.i_vld & bus.i_sop;
    accept_s    = bus.i_vld & (bus.i_sop | (state_r == ST_BURST));
    err_s       = start_s & (state_r == ST_BURST);
    last_s      = accept_s & ~start_s & (cnt_r == LAST_IDX);
    idx_s       = start_s ? {AW{1'b0}} : cnt_r;
    beat_ch_s   = start_s ? bus.i_ch : ch_r;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (start_s) begin
      state_nxt_s = ST_BURST;
      cnt_nxt_s   = AW'(1);
    end else if (accept_s) begin
      if (last_s) begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {AW{1'b0}};
      end else begin
        cnt_nxt_s   = cnt_r + AW'(1);
      end
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // FSM, word counter and latched channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AW{1'b0}};
      ch_r    <= {CHW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_BURST);
      if (start_s) ch_r <= bus.i_ch;
    end
  end

  // Stage 1: register the decoded beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_r  <= 1'b0;
      s1_last_r <= 1'b0;
      s1_err_r  <= 1'b0;
      s1_idx_r  <= {AW{1'b0}};
      s1_ch_r   <= {CHW{1'b0}};
      s1_dat_r  <= {DW{1'b0}};
    end else begin
      s1_vld_r  <= accept_s;
      s1_last_r <= last_s;
      s1_err_r  <= err_s;
      s1_idx_r  <= idx_s;
      s1_ch_r   <= beat_ch_s;
      s1_dat_r  <= bus.i_dat;
    end
  end

  // Stage 2: output registers; address/data/channel hold between beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_r     <= 1'b0;
      wlast_r   <= 1'b0;
      sop_err_r <= 1'b0;
      waddr_r   <= {AW{1'b0}};
      wch_r     <= {CHW{1'b0}};
      wdata_r   <= {DW{1'b0}};
    end else begin
      wen_r     <= s1_vld_r;
      wlast_r   <= s1_vld_r & s1_last_r;
      sop_err_r <= s1_vld_r & s1_err_r;
      if (s1_vld_r) begin
        waddr_r <= s1_idx_r;
        wch_r   <= s1_ch_r;
        wdata_r <= s1_dat_r;
      end
    end
  end

  assign bus.o_cpri_wen   = wen_r;
  assign bus.o_cpri_wch   = wch_r;
  assign bus.o_cpri_waddr = waddr_r;
  assign bus.o_cpri_wdata = wdata_r;
  assign bus.o_cpri_wlast = wlast_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_sop_err    = sop_err_r;

`ifdef CPRI_TX_BURST_STAT_EN
  logic [15:0] burst_cnt_r, err_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters driven from the registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt_r <= 16'd0;
      err_cnt_r   <= 16'd0;
    end else begin
      if (wlast_r)   burst_cnt_r <= sat_inc(burst_cnt_r);
      if (sop_err_r) err_cnt_r   <= sat_inc(err_cnt_r);
    end
  end

  assign bus.o_burst_cnt = burst_cnt_r;
  assign bus.o_err_cnt   = err_cnt_r;
`endif
endmodule
